mem_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch port (I) and load/store port (D). Sits between the fetch/LSU units and the RAM, enabling a von Neumann memory for the multicycle core. It keeps one transaction in flight, counts the memory's fixed read latency, and routes the response back to the port that owns the transaction.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int unsigned MAX_LATENCY = 4;
  localparam int unsigned CNT_W       = $clog2(MAX_LATENCY);

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch (I) and load/store (D) requesters.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_owner,
  output logic   win_valid,
  output owner_e win_owner
);

`ifdef MEM_ARB_RR_EN
  // On contention the port that was not granted last wins.
  always_comb begin
    win_valid = i_req | d_req;
    win_owner = OWN_I;
    if (i_req && d_req) begin
      win_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      win_owner = OWN_D;
    end
  end
`else
  // D always wins; the last-owner history is not needed here.
  always_comb begin
    win_valid = i_req | d_req;
    win_owner = OWN_I;
    if (d_req) begin
      win_owner = OWN_D;
    end
  end

  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D).
// One transaction in flight; the fixed read latency is counted down and the
// response is routed back to the owning port. Back-to-back issue is allowed in
// the response cycle. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_arbiter: LATENCY=%0d outside legal range 1..%0d", LATENCY, MAX_LATENCY);
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  owner_e           owner;
  logic             we_q;
  owner_e           last_owner;

  logic             win_valid;
  owner_e           win_owner;
  logic             resp;
  logic             can_issue;
  logic             issue_raw;
  logic             issue;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );

  // Response cycle doubles as the back-to-back issue slot.
  assign resp      = (state == S_WAIT) && (cnt == '0);
  assign can_issue = (state == S_IDLE) || resp;
  assign issue_raw = can_issue && win_valid;
  // Grants and memory strobes are suppressed while reset is asserted.
  assign issue     = issue_raw && reset_n;

  // Transaction state: issue loads the latency counter, response returns to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      owner <= OWN_I;
      we_q  <= 1'b0;
    end else if (issue_raw) begin
      state <= S_WAIT;
      cnt   <= CNT_W'(LATENCY - 1);
      owner <= win_owner;
      we_q  <= (win_owner == OWN_D) && d_we;
    end else if (state == S_WAIT) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        state <= S_IDLE;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remembers the most recent grant for round-robin fairness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_I;
    end else if (issue_raw) begin
      last_owner <= win_owner;
    end
  end
`else
  assign last_owner = OWN_I;
`endif

  // Issue-cycle grant and memory drive, taken straight from the winner.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      mem_en = 1'b1;
      if (win_owner == OWN_D) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        i_gnt    = 1'b1;
        mem_be   = '1;
        mem_addr = i_addr;
      end
    end
  end

  // Response routing: only the owner sees data, and write acks carry zero.
  always_comb begin
    i_rvalid = resp && (owner == OWN_I);
    d_rvalid = resp && (owner == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = (d_rvalid && !we_q) ? mem_rdata : '0;
    busy     = (state == S_WAIT);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: one lane per LATENCY 1..4, each with its own
// requesters, latency-accurate memory and transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned BW        = DW / 8;
  localparam int unsigned NWORD     = 16;
  localparam int unsigned RST_CYC   = 3;
  localparam int unsigned PHASE_CYC = 250;
  localparam int unsigned NPHASE    = 4;
  localparam int unsigned LANE_CYC  = RST_CYC + NPHASE * PHASE_CYC;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    int            due;
    bit            own_d;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BW); b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int unsigned L = g + 1;

    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic          done;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    initial begin : run
      logic [DW-1:0] env_mem [NWORD];
      logic [DW-1:0] ref_mem [NWORD];
      logic [DW-1:0] pipe [L];
      resp_t         rq[$];
      resp_t         r;
      int            next_free;
      bit            last_d, win_d;
      bit            i_pend, d_pend, allow_wd, allow_rst;
      int unsigned   p_start, phase;
      bit            op_en, op_we;
      logic [BW-1:0] op_be;
      logic [AW-1:0] op_addr;
      logic [DW-1:0] op_wdata;
      bit            e_ign, e_dgn, e_en, e_we, e_irv, e_drv, e_busy;
      logic [BW-1:0] e_be;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_ird, e_drd;
      string         pre;

      done = 1'b0;  reset_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0;
      for (int k = 0; k < int'(NWORD); k++) begin
        env_mem[k] = $urandom;
        ref_mem[k] = env_mem[k];
      end
      for (int k = 0; k < int'(L); k++) pipe[k] = '0;
      rq.delete();
      next_free = 0; last_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
      op_en = 1'b0; op_we = 1'b0; op_be = '0; op_addr = '0; op_wdata = '0;

      for (int cy = 0; cy < int'(LANE_CYC); cy++) begin
        @(posedge clk);
        #1;
        // Memory: reads appear L cycles after the strobe, garbage otherwise.
        for (int k = int'(L) - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = (op_en && !op_we) ? env_mem[op_addr[5:2]] : DW'($urandom);
        if (op_en && op_we) env_mem[op_addr[5:2]] = merge(env_mem[op_addr[5:2]], op_wdata, op_be);
        mem_rdata = pipe[L-1];

        // Phase 2 holds both requesters permanently busy with no resets.
        if (cy < int'(RST_CYC)) begin
          p_start = 0; allow_wd = 1'b0; allow_rst = 1'b0;
        end else begin
          phase = (cy - RST_CYC) / PHASE_CYC;
          case (phase)
            0:       begin p_start = 30;  allow_wd = 1'b1; allow_rst = 1'b1; end
            1:       begin p_start = 70;  allow_wd = 1'b1; allow_rst = 1'b1; end
            2:       begin p_start = 100; allow_wd = 1'b0; allow_rst = 1'b0; end
            default: begin p_start = 50;  allow_wd = 1'b1; allow_rst = 1'b1; end
          endcase
        end
        reset_n = !((cy < int'(RST_CYC)) || (allow_rst && $urandom_range(0, 63) == 0));

        if (i_pend && allow_wd && $urandom_range(0, 15) == 0) begin
          i_pend = 1'b0;
        end else if (!i_pend && $urandom_range(1, 100) <= p_start) begin
          i_pend = 1'b1;
          i_addr = AW'($urandom_range(0, NWORD - 1) * 4);
        end
        if (d_pend && allow_wd && $urandom_range(0, 15) == 0) begin
          d_pend = 1'b0;
        end else if (!d_pend && $urandom_range(1, 100) <= p_start) begin
          d_pend  = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_be    = BW'($urandom_range(1, (1 << BW) - 1));
          d_addr  = AW'($urandom_range(0, NWORD - 1) * 4);
          d_wdata = DW'($urandom);
        end
        i_req = i_pend;
        d_req = d_pend;

        @(negedge clk);
        // Reference: one outstanding transaction, response exactly L cycles after grant.
        e_ign = 0; e_dgn = 0; e_en = 0; e_we = 0; e_irv = 0; e_drv = 0; e_busy = 0;
        e_be = '0; e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
        if (!reset_n) begin
          rq.delete();
          next_free = 0;
          last_d = 1'b0;
        end else begin
          e_busy = (rq.size() != 0);
          if (rq.size() != 0 && rq[0].due == cy) begin
            r = rq.pop_front();
            e_irv = !r.own_d;
            e_drv = r.own_d;
            if (r.own_d) e_drd = r.data;
            else         e_ird = r.data;
          end
          if (cy >= next_free && (i_req || d_req)) begin
            win_d  = d_req && !(RR_EN && i_req && last_d);
            last_d = win_d;
            e_en   = 1'b1;
            if (win_d) begin
              e_dgn  = 1'b1;
              e_we   = d_we;
              e_be   = d_be;
              e_addr = d_addr;
              e_wd   = d_wdata;
              r.data = d_we ? '0 : ref_mem[d_addr[5:2]];
              if (d_we) ref_mem[d_addr[5:2]] = merge(ref_mem[d_addr[5:2]], d_wdata, d_be);
            end else begin
              e_ign  = 1'b1;
              e_be   = '1;
              e_addr = i_addr;
              r.data = ref_mem[i_addr[5:2]];
            end
            r.due   = cy + int'(L);
            r.own_d = win_d;
            rq.push_back(r);
            next_free = cy + int'(L);
          end
        end

        pre = $sformatf("L%0d cyc%0d", L, cy);
        check({pre, " i_gnt"},     64'(i_gnt),     64'(e_ign));
        check({pre, " d_gnt"},     64'(d_gnt),     64'(e_dgn));
        check({pre, " mem_en"},    64'(mem_en),    64'(e_en));
        check({pre, " mem_we"},    64'(mem_we),    64'(e_we));
        check({pre, " mem_be"},    64'(mem_be),    64'(e_be));
        check({pre, " mem_addr"},  64'(mem_addr),  64'(e_addr));
        check({pre, " mem_wdata"}, 64'(mem_wdata), 64'(e_wd));
        check({pre, " i_rvalid"},  64'(i_rvalid),  64'(e_irv));
        check({pre, " i_rdata"},   64'(i_rdata),   64'(e_ird));
        check({pre, " d_rvalid"},  64'(d_rvalid),  64'(e_drv));
        check({pre, " d_rdata"},   64'(d_rdata),   64'(e_drd));
        check({pre, " busy"},      64'(busy),      64'(e_busy));

        op_en = mem_en; op_we = mem_we; op_be = mem_be; op_addr = mem_addr; op_wdata = mem_wdata;
        if (i_gnt) i_pend = 1'b0;
        if (d_gnt) d_pend = 1'b0;
      end
      done = 1'b1;
    end
  end

  // Bounded wait for all lanes, then report.
  initial begin
    repeat (LANE_CYC + 10) @(posedge clk);
    check("lane0 done", 64'(lane[0].done), 64'd1);
    check("lane1 done", 64'(lane[1].done), 64'd1);
    check("lane2 done", 64'(lane[2].done), 64'd1);
    check("lane3 done", 64'(lane[3].done), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
